// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird score path: BCD digits,
// 3-digit scores, seven-segment patterns (active-low) and a BCD compare.
package flappy_pkg;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [2:0] score_t;  // [2]=hundreds, [1]=tens, [0]=ones

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Most-significant digit decides first
  function automatic logic bcd_gt(score_t a, score_t b);
    if (a[2] != b[2]) return a[2] > b[2];
    if (a[1] != b[1]) return a[1] > b[1];
    return a[0] > b[0];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern; non-decimal codes blank.
module seg7_decode
  import flappy_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) seg = SEG_DIGITS[digit];
  end

endmodule

// File: rtl/score_keeper.sv
// 3-digit BCD score with saturation, freeze on loss, and HEX0-HEX5 drive.
// Define SCORE_KEEPER_BEST_EN to build the best-score register and display.
module score_keeper
  import flappy_pkg::*;
#(
  parameter int BLANK_LEADING = 1,
  parameter int MAX_SCORE     = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       score_in,
  input  logic       lose_in,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       new_best
);

  localparam score_t MAX_BCD = {4'(MAX_SCORE / 100), 4'((MAX_SCORE / 10) % 10),
                                4'(MAX_SCORE % 10)};

  score_t score, score_inc;
  logic   score_d, score_rise;

  assign score_rise = score_in & ~score_d;

  // Ripple BCD increment; holds at the saturation value
  always_comb begin
    score_inc = score;
    if (score != MAX_BCD) begin
      if (score[0] == 4'd9) begin
        score_inc[0] = 4'd0;
        if (score[1] == 4'd9) begin
          score_inc[1] = 4'd0;
          score_inc[2] = score[2] + 4'd1;
        end else begin
          score_inc[1] = score[1] + 4'd1;
        end
      end else begin
        score_inc[0] = score[0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score   <= '0;
      score_d <= 1'b0;
    end else begin
      score_d <= score_in;
      if (restart)                     score <= '0;
      else if (score_rise && !lose_in) score <= score_inc;
    end
  end

  function automatic logic [2:0] lead_blank(score_t s);
    logic [2:0] b;
    b[0] = 1'b0;
    b[1] = (BLANK_LEADING != 0) && (s[2] == 4'd0) && (s[1] == 4'd0);
    b[2] = (BLANK_LEADING != 0) && (s[2] == 4'd0);
    return b;
  endfunction

  logic [2:0]      score_blank;
  logic [2:0][6:0] score_seg;

  assign score_blank = lead_blank(score);

  for (genvar g = 0; g < 3; g++) begin : g_score_seg
    seg7_decode u_dec (.digit(score[g]), .blank(score_blank[g]), .seg(score_seg[g]));
  end

  assign hex0 = score_seg[0];
  assign hex1 = score_seg[1];
  assign hex2 = score_seg[2];

`ifdef SCORE_KEEPER_BEST_EN
  score_t          best;
  logic            lose_d, lose_rise, nb_q;
  logic [2:0]      best_blank;
  logic [2:0][6:0] best_seg;

  assign lose_rise = lose_in & ~lose_d;

  // Compare sees the pre-edge score, so a same-edge restart still records it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best   <= '0;
      lose_d <= 1'b0;
      nb_q   <= 1'b0;
    end else begin
      lose_d <= lose_in;
      if (lose_rise && bcd_gt(score, best)) begin
        best <= score;
        nb_q <= 1'b1;
      end
      if (restart) nb_q <= 1'b0;
    end
  end

  assign best_blank = lead_blank(best);

  for (genvar g = 0; g < 3; g++) begin : g_best_seg
    seg7_decode u_dec (.digit(best[g]), .blank(best_blank[g]), .seg(best_seg[g]));
  end

  assign hex3     = best_seg[0];
  assign hex4     = best_seg[1];
  assign hex5     = best_seg[2];
  assign new_best = nb_q;
`else
  assign hex3     = SEG_BLANK;
  assign hex4     = SEG_BLANK;
  assign hex5     = SEG_BLANK;
  assign new_best = 1'b0;
`endif

endmodule
